// File: rtl/muldiv_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// muldiv_ctrl_pkg
// Shared definitions for the multi-cycle multiply/divide sequencer:
//   - ALU op codes for MULT/MULTU/DIV/DIVU (reused ALU encodings)
//   - sequencer state encoding
//   - small op-decode helper functions
// No ports (package).
// ---------------------------------------------------------------------------
package muldiv_ctrl_pkg;

   localparam int MD_W = 32;

   localparam logic [3:0] ALU_MULT  = 4'd8;
   localparam logic [3:0] ALU_MULTU = 4'd9;
   localparam logic [3:0] ALU_DIV   = 4'd10;
   localparam logic [3:0] ALU_DIVU  = 4'd11;

   typedef enum logic [1:0] {
      MD_IDLE = 2'd0,
      MD_RUN  = 2'd1,
      MD_FIX  = 2'd2,
      MD_DONE = 2'd3
   } mdState_e;

   // True for the four op codes this unit executes; anything else is ignored
   function automatic logic isMulDivOp(input logic [3:0] op);
      return (op == ALU_MULT) || (op == ALU_MULTU) ||
             (op == ALU_DIV)  || (op == ALU_DIVU);
   endfunction

   function automatic logic isDivOp(input logic [3:0] op);
      return (op == ALU_DIV) || (op == ALU_DIVU);
   endfunction

   function automatic logic isSignedOp(input logic [3:0] op);
      return (op == ALU_MULT) || (op == ALU_DIV);
   endfunction

endpackage

// File: rtl/muldiv_step.sv
// ---------------------------------------------------------------------------
// muldiv_step
// One combinational iteration of the radix-2 shift-add multiplier or the
// restoring divider. The 2W-bit work register is {upper, lower}:
//   multiply: upper = partial product, lower = remaining multiplier bits
//   divide:   upper = partial remainder, lower = dividend/quotient bits
// Ports:
//   i_acc     in  2W  current work register
//   i_operand in  W   multiplicand (multiply) or divisor (divide) magnitude
//   i_isDiv   in  1   1 = divide step, 0 = multiply step
//   o_acc     out 2W  work register after this iteration
// ---------------------------------------------------------------------------
module muldiv_step
   import muldiv_ctrl_pkg::*;
#(
   parameter int W = MD_W
) (
   input  logic [2*W-1:0] i_acc,
   input  logic [W-1:0]   i_operand,
   input  logic           i_isDiv,
   output logic [2*W-1:0] o_acc
);

   logic [W-1:0] w_hi;
   logic [W-1:0] w_lo;
   logic [W:0]   w_sum;
   logic [W:0]   w_trial;

   // The multiply add keeps its carry in bit W so the right shift brings it
   // into the product. For divide, the shifted remainder needs W+1 bits and
   // the trial difference is negative exactly when its top bit is set,
   // because the partial remainder is always below the divisor.
   always_comb begin
      w_hi    = i_acc[2*W-1:W];
      w_lo    = i_acc[W-1:0];
      w_sum   = {1'b0, w_hi} + {1'b0, i_operand};
      w_trial = {w_hi, w_lo[W-1]} - {1'b0, i_operand};
      o_acc   = i_acc;
      if (i_isDiv) begin
         if (!w_trial[W]) begin
            o_acc = {w_trial[W-1:0], w_lo[W-2:0], 1'b1};
         end else begin
            o_acc = {w_hi[W-2:0], w_lo[W-1], w_lo[W-2:0], 1'b0};
         end
      end else if (w_lo[0]) begin
         o_acc = {w_sum, w_lo[W-1:1]};
      end else begin
         o_acc = {1'b0, w_hi, w_lo[W-1:1]};
      end
   end

endmodule

// File: rtl/muldiv_ctrl.sv
// ---------------------------------------------------------------------------
// muldiv_ctrl
// Multi-cycle sequencer for MULT/MULTU/DIV/DIVU. Accepts one op, iterates
// muldiv_step W times on operand magnitudes, applies sign correction and
// writes HI/LO. Also services MTHI/MTLO when idle.
// Ports:
//   clk_87    in  1  clock, rising edge
//   rst_87    in  1  synchronous active-high reset
//   start_87  in  1  op request, sampled with op_87/arg_a_87/arg_b_87
//   op_87     in  4  ALU op code
//   arg_a_87  in  W  multiplicand / dividend
//   arg_b_87  in  W  multiplier / divisor
//   wr_hi_87  in  1  MTHI strobe
//   wr_lo_87  in  1  MTLO strobe
//   wdata_87  in  W  MTHI/MTLO data
//   busy_87   out 1  op in flight (RUN or FIX)
//   done_87   out 1  one-cycle pulse, HI/LO valid
//   hi_87     out W  HI register
//   lo_87     out W  LO register
// ---------------------------------------------------------------------------
module muldiv_ctrl
   import muldiv_ctrl_pkg::*;
#(
   parameter int W     = MD_W,
   parameter int CNT_W = $clog2(W)
) (
   input  logic         clk_87,
   input  logic         rst_87,
   input  logic         start_87,
   input  logic [3:0]   op_87,
   input  logic [W-1:0] arg_a_87,
   input  logic [W-1:0] arg_b_87,
   input  logic         wr_hi_87,
   input  logic         wr_lo_87,
   input  logic [W-1:0] wdata_87,
   output logic         busy_87,
   output logic         done_87,
   output logic [W-1:0] hi_87,
   output logic [W-1:0] lo_87
);

   mdState_e         r_state;
   mdState_e         w_nextState;
   logic [CNT_W-1:0] r_cnt;
   logic [2*W-1:0]   r_acc;
   logic [2*W-1:0]   w_stepAcc;
   logic [W-1:0]     r_operand;
   logic [W-1:0]     r_hi;
   logic [W-1:0]     r_lo;
   logic             r_isDiv;
   logic             r_divz;
   logic             r_negQ;
   logic             r_negR;

   logic             w_accept;
   logic             w_divzStart;
   logic             w_signA;
   logic             w_signB;
   logic [W-1:0]     w_magA;
   logic [W-1:0]     w_magB;
   logic [2*W-1:0]   w_product;
   logic [W-1:0]     w_quo;
   logic [W-1:0]     w_rem;

   muldiv_step #(.W(W)) u_step (
      .i_acc     (r_acc),
      .i_operand (r_operand),
      .i_isDiv   (r_isDiv),
      .o_acc     (w_stepAcc)
   );

   // Operand preparation: the datapath always works on magnitudes, so the
   // signed ops strip their signs here and remember them for the FIX state.
   always_comb begin
      w_signA     = isSignedOp(op_87) & arg_a_87[W-1];
      w_signB     = isSignedOp(op_87) & arg_b_87[W-1];
      w_magA      = w_signA ? (-arg_a_87) : arg_a_87;
      w_magB      = w_signB ? (-arg_b_87) : arg_b_87;
      w_divzStart = isDivOp(op_87) && (arg_b_87 == '0);
   end

   // Sign correction applied when leaving the iteration. The most negative
   // dividend divided by -1 wraps back to itself, which is the wanted result.
   always_comb begin
      w_product = r_negQ ? (-r_acc) : r_acc;
      w_quo     = r_negQ ? (-r_acc[W-1:0]) : r_acc[W-1:0];
      w_rem     = r_negR ? (-r_acc[2*W-1:W]) : r_acc[2*W-1:W];
   end

   // Next-state logic. A new op can be taken from IDLE or straight from DONE
   // so back-to-back ops have no idle bubble; starts while busy are dropped.
   always_comb begin
      w_nextState = r_state;
      w_accept    = 1'b0;
      case (r_state)
         MD_IDLE, MD_DONE: begin
            if (start_87 && isMulDivOp(op_87)) begin
               w_accept    = 1'b1;
               w_nextState = w_divzStart ? MD_FIX : MD_RUN;
            end else if (r_state == MD_DONE) begin
               w_nextState = MD_IDLE;
            end
         end
         MD_RUN: begin
            if (r_cnt == '0) begin
               w_nextState = MD_FIX;
            end
         end
         MD_FIX: begin
            w_nextState = MD_DONE;
         end
         default: begin
            w_nextState = MD_IDLE;
         end
      endcase
   end

   // State, work registers and HI/LO. The divide-by-zero path parks the raw
   // dividend in the low half of the work register so FIX can copy it to HI.
   // MTHI/MTLO only land when idle and no op is being accepted this cycle.
   always_ff @(posedge clk_87) begin
      if (rst_87) begin
         r_state   <= MD_IDLE;
         r_cnt     <= '0;
         r_acc     <= '0;
         r_operand <= '0;
         r_hi      <= '0;
         r_lo      <= '0;
         r_isDiv   <= 1'b0;
         r_divz    <= 1'b0;
         r_negQ    <= 1'b0;
         r_negR    <= 1'b0;
      end else begin
         r_state <= w_nextState;
         if (w_accept) begin
            r_isDiv   <= isDivOp(op_87);
            r_divz    <= w_divzStart;
            r_negQ    <= w_signA ^ w_signB;
            r_negR    <= w_signA;
            r_cnt     <= CNT_W'(W-1);
            r_operand <= isDivOp(op_87) ? w_magB : w_magA;
            if (w_divzStart) begin
               r_acc <= {{W{1'b0}}, arg_a_87};
            end else begin
               r_acc <= {{W{1'b0}}, isDivOp(op_87) ? w_magA : w_magB};
            end
         end else if (r_state == MD_RUN) begin
            r_acc <= w_stepAcc;
            if (r_cnt != '0) begin
               r_cnt <= r_cnt - CNT_W'(1);
            end
         end

         if (r_state == MD_FIX) begin
            if (r_divz) begin
               r_hi <= r_acc[W-1:0];
               r_lo <= '1;
            end else if (r_isDiv) begin
               r_hi <= w_rem;
               r_lo <= w_quo;
            end else begin
               r_hi <= w_product[2*W-1:W];
               r_lo <= w_product[W-1:0];
            end
         end else if (!busy_87 && !w_accept) begin
            if (wr_hi_87) begin
               r_hi <= wdata_87;
            end
            if (wr_lo_87) begin
               r_lo <= wdata_87;
            end
         end
      end
   end

   // Status and result outputs, all derived directly from registered state
   always_comb begin
      busy_87 = (r_state == MD_RUN) || (r_state == MD_FIX);
      done_87 = (r_state == MD_DONE);
      hi_87   = r_hi;
      lo_87   = r_lo;
   end

endmodule
